// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle between the OTTER pipeline and its hazard unit.
// The master side is the datapath; the slave side is the hazard controller.
interface pipeline_hazard_ctrl_if;
  logic [4:0] Rs1D;
  logic [4:0] Rs2D;
  logic [4:0] Rs1E;
  logic [4:0] Rs2E;
  logic [4:0] RdE;
  logic [4:0] RdM;
  logic [4:0] RdW;
  logic       RegWriteM;
  logic       RegWriteW;
  logic [1:0] ResultSrcE;
  logic       PCSrcE;
  logic       MulStartE;
  logic       MemReqM;
  logic       MemReadyM;
  logic       StallF;
  logic       StallD;
  logic       StallE;
  logic       StallM;
  logic       FlushD;
  logic       FlushE;
  logic       FlushM;
  logic       FlushW;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;
  logic       MemFault;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE,
    output PCSrcE, MulStartE, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushM, FlushW,
    input  ForwardAE, ForwardBE, MemFault
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE,
    input  PCSrcE, MulStartE, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushM, FlushW,
    output ForwardAE, ForwardBE, MemFault
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// OTTER 5-stage hazard controller: forwarding, load-use, branch, multiply, mem wait.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int MUL_LAT     = 4,
  parameter int MEM_TIMEOUT = 256
) (
  input  logic CLK,
  input  logic RST_N,
  pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCycles,
  output logic [31:0] BranchFlushes
`endif
);

  localparam int MCW = $clog2(MUL_LAT + 1);
  localparam int MEMW = $clog2(MEM_TIMEOUT + 1);
  localparam bit MUL_MC = (MUL_LAT >= 2);
  localparam logic [MCW-1:0] MUL_INIT =
    MCW'(MUL_LAT >= 2 ? MUL_LAT - 2 : 0);
  localparam logic [MEMW-1:0] MEM_MAX = MEMW'(MEM_TIMEOUT);
  localparam logic [MEMW-1:0] MEM_TRIP = MEMW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN,
    MUL_WAIT,
    MUL_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [MCW-1:0]  mul_cnt_q, mul_cnt_d;
  logic [MEMW-1:0] mem_cnt_q, mem_cnt_d;
  logic            fault_q, fault_d;

  logic mem_stall;
  logic mul_stall;
  logic lw_stall;

  function automatic logic [1:0] fwd(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != 5'd0 && rs == rd_m && we_m)
      sel = 2'b10;
    else if (rs != 5'd0 && rs == rd_w && we_w)
      sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    mem_stall = hz.MemReqM && !hz.MemReadyM;
    lw_stall  = (hz.ResultSrcE == 2'b01) &&
                (hz.RdE != 5'd0) &&
                (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
    mul_stall = 1'b0;
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    unique case (state_q)
      RUN: begin
        if (hz.MulStartE && MUL_MC) begin
          mul_stall = 1'b1;
          mul_cnt_d = MUL_INIT;
          state_d   = MUL_WAIT;
        end
      end
      MUL_WAIT: begin
        mul_stall = (mul_cnt_q != '0);
        if (mul_cnt_q != '0)
          mul_cnt_d = mul_cnt_q - MCW'(1);
        else
          state_d = mem_stall ? MUL_HOLD : RUN;
      end
      MUL_HOLD: begin
        if (!mem_stall)
          state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Saturating wait counter; fault trips as the count reaches MEM_TIMEOUT-1
  always_comb begin
    mem_cnt_d = '0;
    if (mem_stall)
      mem_cnt_d = (mem_cnt_q == MEM_MAX) ? MEM_MAX
                                          : mem_cnt_q + MEMW'(1);
    fault_d = fault_q | (mem_stall && mem_cnt_d >= MEM_TRIP);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= RUN;
      mul_cnt_q <= '0;
      mem_cnt_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
      mem_cnt_q <= mem_cnt_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.StallE    = 1'b0;
    hz.StallM    = 1'b0;
    hz.FlushD    = 1'b1;
    hz.FlushE    = 1'b1;
    hz.FlushM    = 1'b1;
    hz.FlushW    = 1'b1;
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    if (RST_N) begin
      hz.StallF    = mem_stall | mul_stall | lw_stall;
      hz.StallD    = mem_stall | mul_stall | lw_stall;
      hz.StallE    = mem_stall | mul_stall;
      hz.StallM    = mem_stall;
      hz.FlushD    = hz.PCSrcE && !(mem_stall | mul_stall);
      hz.FlushE    = (lw_stall | hz.PCSrcE) &&
                     !(mem_stall | mul_stall);
      hz.FlushM    = mul_stall && !mem_stall;
      hz.FlushW    = mem_stall;
      hz.ForwardAE = fwd(hz.Rs1E, hz.RdM, hz.RegWriteM,
                         hz.RdW, hz.RegWriteW);
      hz.ForwardBE = fwd(hz.Rs2E, hz.RdM, hz.RegWriteM,
                         hz.RdW, hz.RegWriteW);
    end
  end

  assign hz.MemFault = fault_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hz.StallF)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (hz.FlushD)
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign StallCycles   = stall_cnt_q;
  assign BranchFlushes = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
// Runs with MUL_LAT=4 and MEM_TIMEOUT=8.
module tb_pipeline_hazard_ctrl;

  logic CLK;
  logic RST_N;
  int   n_assert;
  int   n_fail;

  pipeline_hazard_ctrl_if hz();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCycles;
  logic [31:0] BranchFlushes;
`endif

  pipeline_hazard_ctrl #(
    .MUL_LAT    (4),
    .MEM_TIMEOUT(8)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .hz   (hz)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCycles  (StallCycles),
    .BranchFlushes(BranchFlushes)
`endif
  );

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW}
  logic [7:0] ctl;
  assign ctl = {hz.StallF, hz.StallD, hz.StallE, hz.StallM,
                hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    hz.Rs1D = 5'd0; hz.Rs2D = 5'd0;
    hz.Rs1E = 5'd0; hz.Rs2E = 5'd0;
    hz.RdE = 5'd0; hz.RdM = 5'd0; hz.RdW = 5'd0;
    hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
    hz.ResultSrcE = 2'b00;
    hz.PCSrcE = 1'b0; hz.MulStartE = 1'b0;
    hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;
  endtask

  task automatic rand_in();
    hz.Rs1D = 5'($urandom); hz.Rs2D = 5'($urandom);
    hz.Rs1E = 5'($urandom); hz.Rs2E = 5'($urandom);
    hz.RdE = 5'($urandom); hz.RdM = 5'($urandom);
    hz.RdW = 5'($urandom);
    hz.RegWriteM = 1'($urandom); hz.RegWriteW = 1'($urandom);
    hz.ResultSrcE = 2'($urandom);
    hz.PCSrcE = 1'($urandom); hz.MulStartE = 1'($urandom);
    hz.MemReqM = 1'($urandom); hz.MemReadyM = 1'($urandom);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    RST_N    = 1'b0;
    rand_in();
    #1;
    // reset with random inputs
    for (int i = 0; i < 2; i++) begin
      chk("rst_ctl", 32'(ctl), 32'h0F);
      chk("rst_fwd", 32'({hz.ForwardAE, hz.ForwardBE}), 32'h0);
      tick();
      rand_in();
      #1;
      chk("rst_fault", 32'(hz.MemFault), 32'h0);
    end
    idle();
    RST_N = 1'b1;
    #1;
    chk("rel_ctl", 32'(ctl), 32'h00);
    tick();
    chk("rel_ctl2", 32'(ctl), 32'h00);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_zero", StallCycles, 32'h0);
`endif

    // forwarding
    hz.RdM = 5'd5; hz.RegWriteM = 1'b1;
    hz.RdW = 5'd5; hz.RegWriteW = 1'b1;
    hz.Rs1E = 5'd5; hz.Rs2E = 5'd0;
    #1;
    chk("fwdA_M", 32'(hz.ForwardAE), 32'h2);
    chk("fwdB_x0", 32'(hz.ForwardBE), 32'h0);
    hz.RegWriteM = 1'b0;
    #1;
    chk("fwdA_W", 32'(hz.ForwardAE), 32'h1);
    hz.Rs2E = 5'd5; hz.RdW = 5'd9;
    #1;
    chk("fwdB_none", 32'(hz.ForwardBE), 32'h0);
    hz.RdM = 5'd9; hz.RegWriteM = 1'b1;
    hz.Rs2E = 5'd9; hz.Rs1E = 5'd0;
    #1;
    chk("fwdB_M", 32'(hz.ForwardBE), 32'h2);
    chk("fwdA_x0", 32'(hz.ForwardAE), 32'h0);
    idle();
    #1;

    // branch, load-use + branch, load-use
    hz.PCSrcE = 1'b1;
    #1;
    chk("branch", 32'(ctl), 32'h0C);
    hz.ResultSrcE = 2'b01; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
    #1;
    chk("lw_branch", 32'(ctl), 32'hCC);
    hz.PCSrcE = 1'b0;
    #1;
    chk("lw_use", 32'(ctl), 32'hC4);
    tick();
    hz.ResultSrcE = 2'b00; hz.RdE = 5'd0;
    #1;
    chk("lw_done", 32'(ctl), 32'h00);
    hz.ResultSrcE = 2'b01; hz.Rs1D = 5'd0; hz.Rs2D = 5'd0;
    #1;
    chk("lw_x0", 32'(ctl), 32'h00);
    idle();
    tick();

    // multiply, branch resolved while held
    hz.MulStartE = 1'b1;
    #1;
    chk("mul_c1", 32'(ctl), 32'hE2);
    tick();
    hz.PCSrcE = 1'b1;
    #1;
    chk("mul_c2", 32'(ctl), 32'hE2);
    tick();
    chk("mul_c3", 32'(ctl), 32'hE2);
    tick();
    chk("mul_c4", 32'(ctl), 32'h0C);
    tick();
    idle();
    #1;
    chk("mul_after", 32'(ctl), 32'h00);
    tick();

    // multiply overlapped by 5 memory wait cycles
    hz.MulStartE = 1'b1;
    #1;
    chk("ovl_c1", 32'(ctl), 32'hE2);
    tick();
    hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("ovl_wait", 32'(ctl), 32'hF1);
      tick();
    end
    hz.MemReadyM = 1'b1;
    #1;
    chk("ovl_rel", 32'(ctl), 32'h00);
    chk("ovl_fault", 32'(hz.MemFault), 32'h0);
    tick();
    idle();
    #1;
    chk("ovl_after", 32'(ctl), 32'h00);
    tick();

    // timeout with MEM_TIMEOUT=8
    hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      #1;
      chk("to_ctl", 32'(ctl), 32'hF1);
      chk("to_fault", 32'(hz.MemFault), (k >= 8) ? 32'h1 : 32'h0);
      tick();
    end
    hz.MemReadyM = 1'b1;
    #1;
    chk("to_sticky", 32'(hz.MemFault), 32'h1);
    chk("to_rel", 32'(ctl), 32'h00);
    tick();
    idle();
    tick();
    chk("to_sticky2", 32'(hz.MemFault), 32'h1);
    RST_N = 1'b0;
    tick();
    chk("to_clr", 32'(hz.MemFault), 32'h0);
    RST_N = 1'b1;
    tick();

    // reset in the middle of a multiply
    hz.MulStartE = 1'b1;
    tick();
    chk("mr_busy", 32'(ctl), 32'hE2);
    RST_N = 1'b0;
    #1;
    chk("mr_rst", 32'(ctl), 32'h0F);
    tick();
    hz.MulStartE = 1'b0;
    RST_N = 1'b1;
    #1;
    chk("mr_clean", 32'(ctl), 32'h00);
    tick();
    chk("mr_clean2", 32'(ctl), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
